reg_ctrl: RTL and testbench
===========================

// Module: reg_ctrl
// PURPOSE
//  Memory-mapped control register bank on a simple sel/wr/ready bus. A master drives
//  addr/sel/wr/wdata (bundled in the interface reg_if, same signal names); the block
//  stores DEPTH words, writes with zero wait states, and returns read data with one
//  wait state flagged by ready. Sits between a bus master/driver and configuration logic.
// PARAMETERS
//  ADDR_WIDTH  8        address bits; word-addressed
//  DATA_WIDTH  16       register and data-bus width
//  DEPTH       256      number of registers (2**ADDR_WIDTH)
//  RESET_VAL   16'h1234 value loaded into every register on reset
// PORTS
//  clk    in   1           clock, all state on rising edge
//  rstn   in   1           reset, asynchronous, active-low
//  addr   in   ADDR_WIDTH  register index
//  sel    in   1           transfer request; high = access this cycle
//  wr     in   1           1 = write, 0 = read (valid while sel=1)
//  wdata  in   DATA_WIDTH  write data (valid while sel=1 and wr=1)
//  rdata  out  DATA_WIDTH  read data, registered
//  ready  out  1           1 = block can accept a transfer / read data valid
// BEHAVIOUR
//  - Reset (rstn=0, async, any time incl. mid-transfer): all DEPTH registers = RESET_VAL,
//    rdata = 0, ready = 1; any pending read is dropped. Release is sampled at next clk edge.
//  - Transfer accepted at a rising edge only when sel=1 and ready=1.
//  - Write (sel=1, wr=1, ready=1): reg[addr] <= wdata at that edge; ready stays 1;
//    back-to-back writes every cycle allowed. rdata unchanged by writes.
//  - Read (sel=1, wr=0, ready=1) at edge N: rdata <= reg[addr] at edge N; ready <= 0 at
//    edge N; ready <= 1 at edge N+1 regardless of sel. Master holds sel/addr/wr until it
//    sees ready=1 again; data is valid when ready returns high (after edge N+1).
//  - While ready=0, sel/wr/addr/wdata are ignored (no write, no new read).
//  - rdata holds the last read value until the next accepted read or reset.
//  - sel=0: no state change, ready stays/returns 1.
//  - Write then read of same address in consecutive accepted cycles returns the new data.
//  - addr always in range (DEPTH = 2**ADDR_WIDTH); no wrap/decoding errors possible.
//  - Unwritten registers read as RESET_VAL.
//  - No X propagation from outputs after reset; registers not reset-gated by sel.
// TESTING
//  1. Reset: rstn=0 for 1 cycle -> ready=1, rdata=0; read addr 8'h00 -> 16'h1234.
//  2. Write addr 8'h05 data 16'hABCD (sel=1,wr=1 one cycle) -> ready stays 1; read 8'h05
//     -> ready low exactly 1 cycle, then rdata=16'hABCD with ready=1.
//  3. Back-to-back writes 8'h00..8'h03 (data 16'h0001..16'h0004), then reads -> each
//     returns its value; untouched 8'hFF returns 16'h1234.
//  4. Held read: keep sel=1,wr=0 on 8'h05 for 4 cycles -> ready pattern 0,1,0,1; rdata
//     stays 16'hABCD; no write occurs when wr toggles during ready=0.
//  5. Reset mid-read: assert rstn=0 between clocks while ready=0 -> ready=1, rdata=0
//     immediately; 8'h05 reads back 16'h1234 afterwards.
//  6. sel=0 with wr=1, wdata=16'hFFFF -> no register changes, ready=1.

Source files
------------

// File: rtl/reg_ctrl.sv
// Control register bank on a sel/wr/ready bus.
// Zero-wait writes; reads return registered data after one wait state.
module reg_ctrl #(
   parameter int                  ADDR_WIDTH = 8,
   parameter int                  DATA_WIDTH = 16,
   parameter int                  DEPTH      = 2**ADDR_WIDTH,
   parameter logic [DATA_WIDTH-1:0] RESET_VAL = 16'h1234
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic                  sel,
   input  logic                  wr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  ready
);

   typedef enum logic {
      ST_IDLE,
      ST_RWAIT
   } state_t;

   state_t                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
   logic                    wr_en;
   logic                    rd_en;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         rdata_q <= rdata_d;
      end
   end

   // Requests are only honoured in ST_IDLE; the wait state drops them.
   always_comb begin
      state_d = state_q;
      rdata_d = rdata_q;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            wr_en = sel & wr;
            rd_en = sel & ~wr;
            if (rd_en) begin
               rdata_d = mem_q[addr];
               state_d = ST_RWAIT;
            end
         end
         ST_RWAIT: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= RESET_VAL;
         end
      end else if (wr_en) begin
         mem_q[addr] <= wdata;
      end
   end

   assign rdata = rdata_q;
   assign ready = (state_q == ST_IDLE);

endmodule

// File: tb/tb_reg_ctrl.sv
// Directed self-checking bench for reg_ctrl.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_reg_ctrl;

   logic        clk;
   logic        rstn;
   logic [7:0]  addr;
   logic        sel;
   logic        wr;
   logic [15:0] wdata;
   logic [15:0] rdata;
   logic        ready;

   int checks;
   int errors;

   reg_ctrl dut (
      .clk   (clk),
      .rstn  (rstn),
      .addr  (addr),
      .sel   (sel),
      .wr    (wr),
      .wdata (wdata),
      .rdata (rdata),
      .ready (ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [7:0] a, input logic [15:0] d);
      sel   = 1'b1;
      wr    = 1'b1;
      addr  = a;
      wdata = d;
      cyc();
      sel = 1'b0;
      wr  = 1'b0;
   endtask

   // Holds the request until ready returns, bounded to 8 cycles.
   task automatic do_read(input logic [7:0] a, output logic first_rdy,
                          output int waits, output logic [15:0] d);
      sel  = 1'b1;
      wr   = 1'b0;
      addr = a;
      cyc();
      first_rdy = ready;
      waits = 0;
      while (!ready && waits < 8) begin
         cyc();
         waits++;
      end
      sel = 1'b0;
      d   = rdata;
   endtask

   task automatic test_reset();
      logic fr;
      int w;
      logic [15:0] d;
      rstn = 1'b0;
      sel = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
      cyc();
      checks++;
      if (ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: got %b want 1", ready);
      end
      checks++;
      if (rdata !== 16'h0000) begin
         errors++;
         $display("FAIL reset_rdata: got %h want 0000", rdata);
      end
      rstn = 1'b1;
      cyc();
      do_read(8'h00, fr, w, d);
      checks++;
      if (d !== 16'h1234) begin
         errors++;
         $display("FAIL reset_read00: got %h want 1234", d);
      end
   endtask

   task automatic test_write_read();
      logic fr;
      int w;
      logic [15:0] d;
      do_write(8'h05, 16'hABCD);
      checks++;
      if (ready !== 1'b1) begin
         errors++;
         $display("FAIL write_ready: got %b want 1", ready);
      end
      checks++;
      if (rdata !== 16'h1234) begin
         errors++;
         $display("FAIL write_keeps_rdata: got %h want 1234", rdata);
      end
      do_read(8'h05, fr, w, d);
      checks++;
      if (fr !== 1'b0 || w != 1) begin
         errors++;
         $display("FAIL read_wait: ready %b waits %0d want 0 and 1", fr, w);
      end
      checks++;
      if (d !== 16'hABCD) begin
         errors++;
         $display("FAIL read05: got %h want abcd", d);
      end
   endtask

   task automatic test_back_to_back();
      logic fr;
      int w;
      logic [15:0] d;
      logic [15:0] exp;
      for (int i = 0; i < 4; i++) begin
         do_write(8'(i), 16'(i + 1));
      end
      for (int i = 0; i < 4; i++) begin
         do_read(8'(i), fr, w, d);
         exp = 16'(i + 1);
         checks++;
         if (d !== exp) begin
            errors++;
            $display("FAIL b2b_read%0d: got %h want %h", i, d, exp);
         end
      end
      do_read(8'hFF, fr, w, d);
      checks++;
      if (d !== 16'h1234) begin
         errors++;
         $display("FAIL untouched_ff: got %h want 1234", d);
      end
      do_write(8'h07, 16'h5A5A);
      do_read(8'h07, fr, w, d);
      checks++;
      if (d !== 16'h5A5A) begin
         errors++;
         $display("FAIL wr_then_rd: got %h want 5a5a", d);
      end
   endtask

   task automatic test_held_read();
      logic fr;
      int w;
      logic [15:0] d;
      logic [3:0] pat;
      logic [3:0] exp_pat;
      exp_pat = 4'b1010;
      sel  = 1'b1;
      wr   = 1'b0;
      addr = 8'h05;
      for (int i = 0; i < 4; i++) begin
         cyc();
         pat[3-i] = ready;
         checks++;
         if (rdata !== 16'hABCD) begin
            errors++;
            $display("FAIL held_rdata%0d: got %h want abcd", i, rdata);
         end
         wr    = ~ready;
         wdata = 16'hFFFF;
      end
      sel = 1'b0;
      wr  = 1'b0;
      checks++;
      if (pat !== ~exp_pat) begin
         errors++;
         $display("FAIL held_ready_pat: got %b want 0101", pat);
      end
      do_read(8'h05, fr, w, d);
      checks++;
      if (d !== 16'hABCD) begin
         errors++;
         $display("FAIL held_no_write: got %h want abcd", d);
      end
   endtask

   task automatic test_reset_mid_read();
      logic fr;
      int w;
      logic [15:0] d;
      sel  = 1'b1;
      wr   = 1'b0;
      addr = 8'h05;
      cyc();
      checks++;
      if (ready !== 1'b0) begin
         errors++;
         $display("FAIL midrd_busy: got %b want 0", ready);
      end
      #2;
      rstn = 1'b0;
      #1;
      checks++;
      if (ready !== 1'b1 || rdata !== 16'h0000) begin
         errors++;
         $display("FAIL midrd_async: ready %b rdata %h want 1 0000", ready, rdata);
      end
      sel = 1'b0;
      cyc();
      rstn = 1'b1;
      cyc();
      do_read(8'h05, fr, w, d);
      checks++;
      if (d !== 16'h1234) begin
         errors++;
         $display("FAIL midrd_reread: got %h want 1234", d);
      end
   endtask

   task automatic test_sel_zero();
      logic fr;
      int w;
      logic [15:0] d;
      sel   = 1'b0;
      wr    = 1'b1;
      addr  = 8'h01;
      wdata = 16'hFFFF;
      cyc();
      cyc();
      checks++;
      if (ready !== 1'b1) begin
         errors++;
         $display("FAIL sel0_ready: got %b want 1", ready);
      end
      wr = 1'b0;
      do_read(8'h01, fr, w, d);
      checks++;
      if (d !== 16'h1234) begin
         errors++;
         $display("FAIL sel0_nowrite: got %h want 1234", d);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_write_read();
      test_back_to_back();
      test_held_read();
      test_reset_mid_read();
      test_sel_zero();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
